// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : DEPTH-stage valid/ready pipeline register with bubble
//                collapse, synchronous flush and registered occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_d;
    logic [OCC_W-1:0]            occ_q;
    logic [OCC_W-1:0]            occ_d;
    logic [DEPTH-1:0]            stage_ready;

    // A stage can take a new word if it is empty or its own word moves on.
    always_comb begin
        stage_ready            = '0;
        stage_ready[DEPTH-1]   = ~v_q[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            stage_ready[i] = ~v_q[i] | stage_ready[i+1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (stage_ready[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (stage_ready[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end
        // Flush only drops valid bits; payload registers keep their contents.
        if (flush) begin
            v_d = '0;
        end
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = stage_ready[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg
//  Description : Scoreboard bench for pipe_reg (WIDTH=8, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               t;
    } ent_t;

    ent_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the pipe is a FIFO whose oldest word appears exactly DEPTH
    // cycles after it entered (nothing ahead of it can stall it).
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            bit   exp_ov;
            ent_t e;
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (cyc >= q[0].t + DEPTH);
            chk(out_valid === exp_ov, "out_valid", int'(out_valid), int'(exp_ov));
            chk(occupancy === 3'(q.size()), "occupancy", int'(occupancy), q.size());
            chk(in_ready === (!flush && (q.size() < DEPTH || out_ready)), "in_ready",
                int'(in_ready), int'(!flush && (q.size() < DEPTH || out_ready)));
            if (out_valid === 1'b1 && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_word", int'(out_data), 0);
                end else begin
                    e = q.pop_front();
                    chk(out_data === e.d, "out_data", int'(out_data), int'(e.d));
                end
            end
            if (flush) q.delete();
        end
    end

    // Drive one cycle of stimulus; accepted words go into the scoreboard.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl, input logic r);
        ent_t e;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #5;
        if (!rst && in_valid && in_ready === 1'b1) begin
            e.d = in_data;
            e.t = cyc;
            q.push_back(e);
        end
    endtask

    logic [WIDTH-1:0] bp_words [4];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;

        // Reset held two cycles with in_valid high
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(out_valid === 1'b0, "rst_out_valid", int'(out_valid), 0);
        chk(out_data === 8'h00, "rst_out_data", int'(out_data), 0);
        chk(occupancy === 3'd0, "rst_occupancy", int'(occupancy), 0);
        chk(in_ready === 1'b1, "rst_in_ready", int'(in_ready), 1);

        // Latency
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk(out_valid === (k == 4), "lat_valid", int'(out_valid), int'(k == 4));
            if (k == 4) chk(out_data === 8'hA5, "lat_data", int'(out_data), 'hA5);
        end

        // Stream 0x01..0x10 at full rate
        for (int c = 0; c < 20; c++) begin
            step(c < 16, 8'(c + 1), 1'b1, 1'b0, 1'b0);
            if (c >= 4) begin
                chk(out_valid === 1'b1, "stream_valid", int'(out_valid), 1);
                chk(out_data === 8'(c - 3), "stream_data", int'(out_data), c - 3);
            end
            if (c >= 4 && c <= 16) chk(occupancy === 3'd4, "stream_occ", int'(occupancy), 4);
        end

        // Backpressure
        bp_words[0] = 8'h11; bp_words[1] = 8'h22; bp_words[2] = 8'h33; bp_words[3] = 8'h44;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, bp_words[k], 1'b0, 1'b0, 1'b0);
            chk(in_ready === 1'b1, "bp_accept", int'(in_ready), 1);
        end
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk(in_ready === 1'b0, "bp_full_ready", int'(in_ready), 0);
        chk(occupancy === 3'd4, "bp_full_occ", int'(occupancy), 4);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk(in_ready === 1'b1, "bp_pushpop_ready", int'(in_ready), 1);
        chk(out_data === 8'h11, "bp_first_out", int'(out_data), 'h11);
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Bubble collapse
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk(occupancy === 3'd2, "bub_occ", int'(occupancy), 2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(out_valid === 1'b1 && out_data === 8'h66, "bub_first", int'(out_data), 'h66);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(out_valid === 1'b1 && out_data === 8'h77, "bub_second", int'(out_data), 'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush
        step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h83, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        chk(in_ready === 1'b0, "flush_in_ready", int'(in_ready), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk(out_valid === 1'b0, "flush_out_valid", int'(out_valid), 0);
        chk(occupancy === 3'd0, "flush_occ", int'(occupancy), 0);
        for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(out_valid === 1'b0, "flush_no_store", int'(out_valid), 0);

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            logic ordy;
            ordy = (k % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, 8'($urandom), ordy,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk(q.size() == 0, "drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
